// File: rtl/result_collector_if.sv
// Bundle between the dispatcher diagonal lanes, the collector and the downstream row consumer.
// master is the environment side; slave is the collector.
interface result_collector_if;
    logic [31:0]  d1;
    logic [31:0]  d2;
    logic [31:0]  d3;
    logic [31:0]  d4;
    logic [5:0]   count;
    logic         shouldAdd;
    logic         out_valid;
    logic         out_ready;
    logic [1:0]   out_row;
    logic [127:0] out_data;
    logic         done;
    logic         overrun;

    modport master (
        output d1, d2, d3, d4, count, shouldAdd, out_ready,
        input  out_valid, out_row, out_data, done, overrun
    );

    modport slave (
        input  d1, d2, d3, d4, count, shouldAdd, out_ready,
        output out_valid, out_row, out_data, done, overrun
    );
endinterface

// File: rtl/result_collector.sv
// Reassembles a 4x4 matrix from four skewed diagonal lanes over seven steps,
// then drains it row by row over a valid/ready handshake.
module result_collector (
    input logic               clk,
    input logic               rst,
    result_collector_if.slave bus
);
    localparam int unsigned LAST_STEP = 6;
    localparam int unsigned LANES     = 4;

    typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

    state_t       state;
    logic [2:0]   step;
    logic [1:0]   ptr;
    logic [31:0]  m [4][4];
    logic         row_valid;
    logic [1:0]   row_idx;
    logic [127:0] row_data;
    logic         done_pulse;
    logic         overrun_flag;

    logic         trigger_c;
    logic         capture_c;
    logic [31:0]  lane_c [LANES];

    always_comb begin
        trigger_c = (bus.shouldAdd && (bus.count == 6'd6)) ||
                    (!bus.shouldAdd && (bus.count == 6'd7));
        capture_c = ((state == IDLE) && trigger_c) || (state == CAPTURE);
        lane_c[0] = bus.d1;
        lane_c[1] = bus.d2;
        lane_c[2] = bus.d3;
        lane_c[3] = bus.d4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            step         <= 3'd0;
            ptr          <= 2'd0;
            row_valid    <= 1'b0;
            row_idx      <= 2'd0;
            row_data     <= 128'd0;
            done_pulse   <= 1'b0;
            overrun_flag <= 1'b0;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    m[2'(r)][2'(c)] <= 32'd0;
                end
            end
        end else begin
            done_pulse <= 1'b0;

            // Lane i (0-based) carries the diagonal stripe starting at row i; it is live for steps i..6-i.
            for (int i = 0; i < int'(LANES); i++) begin
                if (capture_c && (int'(step) >= i) && (int'(step) <= 6 - i)) begin
                    if (step <= 3'd3) begin
                        m[2'(i)][2'(int'(step) - i)] <= lane_c[i];
                    end else begin
                        m[2'(i + int'(step) - 3)][2'(3 - i)] <= lane_c[i];
                    end
                end
            end

            case (state)
                IDLE: begin
                    if (trigger_c) begin
                        step  <= 3'd1;
                        state <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (trigger_c) begin
                        overrun_flag <= 1'b1;
                    end
                    if (step == 3'(LAST_STEP)) begin
                        // Row 0 is complete by step 3, so it can be loaded alongside the final write.
                        step      <= 3'd0;
                        ptr       <= 2'd0;
                        state     <= DRAIN;
                        row_valid <= 1'b1;
                        row_idx   <= 2'd0;
                        row_data  <= {m[0][0], m[0][1], m[0][2], m[0][3]};
                    end else begin
                        step <= step + 3'd1;
                    end
                end
                DRAIN: begin
                    if (trigger_c) begin
                        overrun_flag <= 1'b1;
                    end
                    if (bus.out_ready) begin
                        if (ptr == 2'd3) begin
                            state      <= IDLE;
                            ptr        <= 2'd0;
                            row_valid  <= 1'b0;
                            done_pulse <= 1'b1;
                        end else begin
                            ptr      <= ptr + 2'd1;
                            row_idx  <= ptr + 2'd1;
                            row_data <= {m[ptr + 2'd1][0], m[ptr + 2'd1][1],
                                         m[ptr + 2'd1][2], m[ptr + 2'd1][3]};
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = row_valid;
    assign bus.out_row   = row_idx;
    assign bus.out_data  = row_data;
    assign bus.done      = done_pulse;
    assign bus.overrun   = overrun_flag;
endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: directed schedules push expected rows,
// a negedge monitor pops and compares each presented row and done pulse.
module tb_result_collector;
    localparam logic [31:0] BEEF = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    result_collector_if bus();
    result_collector dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic [1:0]   row;
        logic [127:0] data;
        int           at;
    } exp_t;

    exp_t         exp_q[$];
    int           done_q[$];
    int           vectors = 0;
    int           errors  = 0;
    int           cyc     = 0;
    logic [31:0]  sched [7][4];
    logic [127:0] rows  [4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, want %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic flag(input string name);
        vectors++;
        errors++;
        $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
    endtask

    // Monitor: every presented row must match the queue head; acceptance must land on the predicted cycle.
    always @(negedge clk) begin
        if (bus.out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                flag("spurious_row");
            end else begin
                check("row_idx", 128'(bus.out_row), 128'(exp_q[0].row));
                check("row_data", bus.out_data, exp_q[0].data);
                if (bus.out_ready === 1'b1) begin
                    check("row_cycle", 128'(cyc), 128'(exp_q[0].at));
                    void'(exp_q.pop_front());
                end
            end
        end
        if (bus.done === 1'b1) begin
            if (done_q.size() == 0) flag("spurious_done");
            else check("done_cycle", 128'(cyc), 128'(done_q.pop_front()));
        end
    end

    task automatic drive_lanes(input logic [31:0] a, b, c, d);
        bus.d1 = a;
        bus.d2 = b;
        bus.d3 = c;
        bus.d4 = d;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"},   128'(bus.out_valid), 128'(0));
        check({tag, "_row"},     128'(bus.out_row),   128'(0));
        check({tag, "_data"},    bus.out_data,        128'(0));
        check({tag, "_done"},    128'(bus.done),      128'(0));
        check({tag, "_overrun"}, 128'(bus.overrun),   128'(0));
    endtask

    // One count ramp 0..20 (then idle); sa selects mode, stall holds ready low on row 1,
    // inject_at forces a count=6 trigger at trigger+inject_at, rst_at pulses reset at that step.
    task automatic run(input bit sa, input bit stall, input int inject_at, input int rst_at);
        int  trig;
        int  t0;
        int  j;
        int  extra;
        bit  prev_rst;
        trig     = sa ? 6 : 7;
        t0       = -1;
        prev_rst = 1'b0;
        for (int k = 0; k <= 26; k++) begin
            @(posedge clk);
            #1;
            if (prev_rst) check_reset_state("mid_reset");
            j = k - trig;
            bus.count     = (k <= 20) ? 6'(k) : 6'd0;
            bus.shouldAdd = sa;
            if (j >= 0 && j <= 6) drive_lanes(sched[j][0], sched[j][1], sched[j][2], sched[j][3]);
            else drive_lanes(BEEF, BEEF, BEEF, BEEF);
            if (k == trig) begin
                t0 = cyc;
                if (rst_at < 0) begin
                    for (int r = 0; r < 4; r++) begin
                        extra = (stall && r >= 1) ? 5 : 0;
                        exp_q.push_back('{row: 2'(r), data: rows[r], at: t0 + 7 + r + extra});
                    end
                    done_q.push_back(t0 + 11 + (stall ? 5 : 0));
                end
            end
            if (t0 >= 0 && inject_at >= 0 && cyc == t0 + inject_at) begin
                bus.count     = 6'd6;
                bus.shouldAdd = 1'b1;
                drive_lanes(32'hBAD00001, 32'hBAD00002, 32'hBAD00003, 32'hBAD00004);
            end
            rst           = (rst_at >= 0 && j == rst_at);
            prev_rst      = rst;
            bus.out_ready = !(stall && t0 >= 0 && cyc >= t0 + 8 && cyc < t0 + 13);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        sched[0] = '{32'h11, BEEF,   BEEF,   BEEF};
        sched[1] = '{32'h12, 32'h21, BEEF,   BEEF};
        sched[2] = '{32'h13, 32'h22, 32'h31, BEEF};
        sched[3] = '{32'h14, 32'h23, 32'h32, 32'h41};
        sched[4] = '{32'h24, 32'h33, 32'h42, BEEF};
        sched[5] = '{32'h34, 32'h43, BEEF,   BEEF};
        sched[6] = '{32'h44, BEEF,   BEEF,   BEEF};
        rows[0]  = {32'h11, 32'h12, 32'h13, 32'h14};
        rows[1]  = {32'h21, 32'h22, 32'h23, 32'h24};
        rows[2]  = {32'h31, 32'h32, 32'h33, 32'h34};
        rows[3]  = {32'h41, 32'h42, 32'h43, 32'h44};

        rst           = 1'b1;
        bus.count     = 6'd0;
        bus.shouldAdd = 1'b0;
        bus.out_ready = 1'b0;
        drive_lanes(32'd0, 32'd0, 32'd0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        run(1'b1, 1'b0, -1, -1);                       // accumulate
        run(1'b0, 1'b0, -1, -1);                       // pass-through
        run(1'b1, 1'b1, -1, -1);                       // backpressure on row 1
        check("overrun_clear", 128'(bus.overrun), 128'(0));
        run(1'b1, 1'b0, 8, -1);                        // second trigger during drain
        check("overrun_set", 128'(bus.overrun), 128'(1));
        run(1'b1, 1'b0, -1, -1);
        check("overrun_sticky", 128'(bus.overrun), 128'(1));
        run(1'b1, 1'b0, -1, 3);                        // reset at capture step 3
        check("overrun_after_rst", 128'(bus.overrun), 128'(0));
        run(1'b1, 1'b0, -1, -1);                       // clean capture after reset
        run(1'b0, 1'b0, 10, -1);                       // trigger on the final-acceptance cycle
        check("overrun_last_row", 128'(bus.overrun), 128'(1));

        check("rows_outstanding", 128'(exp_q.size()), 128'(0));
        check("done_outstanding", 128'(done_q.size()), 128'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 Parameters: none; the matrix is fixed at 4x4 of 32-bit IEEE-754 single-precision words, handled as opaque bits.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 d1, d2, d3, d4  input  32 each  diagonal lanes from the upstream dispatcher stage.
REQ-005 count  input  6  shared schedule counter, same value the dispatcher sees.
REQ-006 shouldAdd  input  1  mode: 1 = accumulate schedule, 0 = pass-through schedule.
REQ-007 out_valid  output  1  a row is presented on out_data.
REQ-008 out_ready  input  1  downstream accepts the presented row.
REQ-009 out_row  output  2  index of the presented row (0 = row 1).
REQ-010 out_data  output  128  row words; [127:96] = column 1 ... [31:0] = column 4.
REQ-011 done  output  1  one-cycle pulse after the last row is accepted.
REQ-012 overrun  output  1  sticky error flag.

Function
REQ-013 States: IDLE, CAPTURE, DRAIN; 3-bit step counter j (0..6); 2-bit row pointer; 16 x 32-bit matrix registers m[r][c].
REQ-014 Trigger condition: count == 6 with shouldAdd = 1, or count == 7 with shouldAdd = 0.
REQ-015 IDLE: on trigger, capture step j = 0, set j to 1, and enter CAPTURE.
REQ-016 CAPTURE: capture one step per cycle for j = 1..6 on consecutive cycles, independent of count and shouldAdd after the trigger. After step 6, clear the row pointer and enter DRAIN.
REQ-017 Step mapping for lane i (1..4) at step j: lane i is valid when i-1 <= j <= 7-i.
REQ-017a Valid lane, j <= 3: written to m[i][j-i+2].
REQ-017b Valid lane, j > 3: written to m[i+j-3][5-i].
REQ-017c Invalid lanes are ignored.
REQ-018 Totals: exactly 16 writes per capture, each matrix element written once.
REQ-019 DRAIN: out_valid = 1; out_row = row pointer; out_data = m[pointer+1][1..4].
REQ-019a out_data and out_row hold stable while out_valid is high and out_ready is low.
REQ-020 Row acceptance: a row is accepted on a cycle with out_valid & out_ready. The pointer increments on acceptance.
REQ-020a Acceptance of row 3 returns the block to IDLE and asserts done for exactly the next cycle.
REQ-021 Minimum latency: trigger cycle to first out_valid = 7 cycles. One full matrix takes 7 + 4 cycles when out_ready is held high.
REQ-022 A trigger seen in CAPTURE or DRAIN is ignored and sets overrun; the matrix and the current drain are unaffected.
REQ-023 A trigger on the same cycle DRAIN returns to IDLE is an overrun, not a new capture.
REQ-024 out_valid = 0 in IDLE and CAPTURE. out_data is don't-care when out_valid = 0 but is driven from the registers; no X.

Reset
REQ-025 rst forces, on the next posedge:
- state = IDLE
- j = 0, row pointer = 0
- all m = 0
- out_valid = 0, out_row = 0, out_data = 0
- done = 0, overrun = 0
REQ-026 rst wins over any trigger or handshake in the same cycle. A capture or drain interrupted by reset is discarded, not resumed.
REQ-027 overrun clears only by rst.

Verification
REQ-028 Accumulate capture:
- Stimulus: shouldAdd = 1, count ramps 0..20, lanes drive tag 32'h000000RC per the REQ-017 schedule, out_ready = 1.
- Response: rows 0..3 = {11,12,13,14}, {21,...,24}, {31,...,34}, {41,...,44}, on cycles trigger+7..+10; done pulses at trigger+11.
REQ-029 Pass-through capture: same as REQ-028 with shouldAdd = 0 and the trigger at count = 7. Response: identical rows, one cycle later.
REQ-030 Backpressure: out_ready = 0 for 5 cycles on row 1, then 1. Response: out_row = 1 and out_data = {21,22,23,24} held stable; no row skipped or duplicated; done fires once.
REQ-031 Overrun: a second count = 6 trigger arrives during DRAIN. Response: overrun = 1 and stays 1; drained data equals the first matrix; the block returns to IDLE.
REQ-032 Reset mid-CAPTURE: rst at step 3. Response: next cycle out_valid = 0 and all m = 0. A subsequent clean capture drains correct tags.
REQ-033 Lanes beyond the schedule: lanes driven 32'hDEADBEEF on invalid steps. Response: no DEADBEEF appears in any output row.
